// File: rtl/rtc_bus_reader.sv
// rtc_bus_reader: periodic read sweep of the RTC multiplexed address/data bus.
// Captures nine BCD registers into shadows and publishes them atomically.
//
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   rd_req            one-cycle request for an immediate sweep
//   hold              another bus master owns the bus; sweeps pause at a gap
//   ad_in             data driven by the RTC
//   ad_out, ad_oe     address/data toward the RTC and its output enable
//   CS_n, AD_n,
//   RD_n, WR_n        active-low RTC strobes
//   ANO .. SEGT       published BCD bytes (high nibble = tens)
//   busy              sweep in progress, including a hold pause
//   upd               one-cycle pulse when new values are published
module rtc_bus_reader #(
    parameter int         T_PHASE        = 5,
    parameter int         REFRESH_CYCLES = 1000000,
    parameter logic [7:0] CMD_XFER       = 8'hF0
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       rd_req,
    input  logic       hold,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       CS_n,
    output logic       AD_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic [7:0] ANO,
    output logic [7:0] MES,
    output logic [7:0] DIA,
    output logic [7:0] HORA,
    output logic [7:0] MIN,
    output logic [7:0] SEG,
    output logic [7:0] HORAT,
    output logic [7:0] MINT,
    output logic [7:0] SEGT,
    output logic       busy,
    output logic       upd
);

    localparam int PW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
    localparam int RW = $clog2(REFRESH_CYCLES);
    localparam logic [PW-1:0] PH_LAST = PW'(T_PHASE - 1);
    localparam logic [RW-1:0] RF_LOAD = RW'(REFRESH_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        A_LO,
        A_HI,
        D_LO,
        D_HI,
        GAP,
        PAUSE,
        COMMIT
    } state_t;

    state_t        state;
    logic [PW-1:0] ph_cnt;
    logic [3:0]    idx;
    logic [3:0]    nidx;
    logic [RW-1:0] rfsh;
    logic          req_lat;
    logic [7:0]    shadow [1:9];
    logic          ph_end;
    logic          is_wr;

    // Index 0 is the transfer command; 1..9 are the register reads.
    function automatic logic [7:0] addr_of(input logic [3:0] i);
        case (i)
            4'd0:    return CMD_XFER;
            4'd1:    return 8'h21;
            4'd2:    return 8'h22;
            4'd3:    return 8'h23;
            4'd4:    return 8'h24;
            4'd5:    return 8'h25;
            4'd6:    return 8'h26;
            4'd7:    return 8'h41;
            4'd8:    return 8'h42;
            4'd9:    return 8'h43;
            default: return 8'h00;
        endcase
    endfunction

    assign ph_end = (ph_cnt == PH_LAST);
    assign is_wr  = (idx == 4'd0);
    assign nidx   = idx + 4'd1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            ph_cnt  <= '0;
            idx     <= '0;
            rfsh    <= '0;
            req_lat <= 1'b0;
            CS_n    <= 1'b1;
            AD_n    <= 1'b1;
            RD_n    <= 1'b1;
            WR_n    <= 1'b1;
            ad_oe   <= 1'b0;
            ad_out  <= '0;
            busy    <= 1'b0;
            upd     <= 1'b0;
            ANO     <= '0;
            MES     <= '0;
            DIA     <= '0;
            HORA    <= '0;
            MIN     <= '0;
            SEG     <= '0;
            HORAT   <= '0;
            MINT    <= '0;
            SEGT    <= '0;
            for (int i = 1; i <= 9; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            upd <= 1'b0;
            if (rfsh != '0) begin
                rfsh <= rfsh - 1'b1;
            end
            if (rd_req) begin
                req_lat <= 1'b1;
            end

            // ph_cnt is back at zero whenever a phase ends, so the
            // entry points into A_LO never need to clear it.
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if ((rfsh == '0 || req_lat) && !hold) begin
                        rfsh    <= RF_LOAD;
                        req_lat <= 1'b0;
                        busy    <= 1'b1;
                        idx     <= '0;
                        state   <= A_LO;
                        CS_n    <= 1'b0;
                        AD_n    <= 1'b0;
                        WR_n    <= 1'b0;
                        ad_oe   <= 1'b1;
                        ad_out  <= CMD_XFER;
                    end
                end
                A_LO: begin
                    if (ph_end) begin
                        ph_cnt <= '0;
                        state  <= A_HI;
                        WR_n   <= 1'b1;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                A_HI: begin
                    if (ph_end) begin
                        ph_cnt <= '0;
                        state  <= D_LO;
                        AD_n   <= 1'b1;
                        if (is_wr) begin
                            WR_n   <= 1'b0;
                            ad_out <= 8'h00;
                        end else begin
                            RD_n   <= 1'b0;
                            ad_oe  <= 1'b0;
                            ad_out <= 8'h00;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                D_LO: begin
                    if (ph_end) begin
                        ph_cnt <= '0;
                        state  <= D_HI;
                        RD_n   <= 1'b1;
                        WR_n   <= 1'b1;
                        if (!is_wr) begin
                            shadow[idx] <= ad_in;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                D_HI: begin
                    if (ph_end) begin
                        ph_cnt <= '0;
                        state  <= GAP;
                        CS_n   <= 1'b1;
                        ad_oe  <= 1'b0;
                        ad_out <= 8'h00;
                    end else begin
                        ph_cnt <= ph_cnt + 1'b1;
                    end
                end
                GAP: begin
                    idx <= nidx;
                    if (idx == 4'd9) begin
                        state <= COMMIT;
                        upd   <= 1'b1;
                        SEG   <= shadow[1];
                        MIN   <= shadow[2];
                        HORA  <= shadow[3];
                        DIA   <= shadow[4];
                        MES   <= shadow[5];
                        ANO   <= shadow[6];
                        SEGT  <= shadow[7];
                        MINT  <= shadow[8];
                        HORAT <= shadow[9];
                    end else if (hold) begin
                        state <= PAUSE;
                    end else begin
                        state  <= A_LO;
                        CS_n   <= 1'b0;
                        AD_n   <= 1'b0;
                        WR_n   <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_out <= addr_of(nidx);
                    end
                end
                PAUSE: begin
                    if (!hold) begin
                        state  <= A_LO;
                        CS_n   <= 1'b0;
                        AD_n   <= 1'b0;
                        WR_n   <= 1'b0;
                        ad_oe  <= 1'b1;
                        ad_out <= addr_of(idx);
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_reader.sv
// tb_rtc_bus_reader: scoreboard bench for rtc_bus_reader with an RTC model,
// a bus protocol monitor and a publish monitor fed by expectation queues.
module tb_rtc_bus_reader;

    localparam int TP = 2;
    localparam int RF = 1000;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       rd_req = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe, CS_n, AD_n, RD_n, WR_n;
    logic [7:0] ANO, MES, DIA, HORA, MIN, SEG, HORAT, MINT, SEGT;
    logic       busy, upd;

    rtc_bus_reader #(
        .T_PHASE(TP),
        .REFRESH_CYCLES(RF),
        .CMD_XFER(8'hF0)
    ) dut (
        .CLK(CLK), .RST(RST), .rd_req(rd_req), .hold(hold),
        .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .CS_n(CS_n), .AD_n(AD_n), .RD_n(RD_n), .WR_n(WR_n),
        .ANO(ANO), .MES(MES), .DIA(DIA), .HORA(HORA), .MIN(MIN),
        .SEG(SEG), .HORAT(HORAT), .MINT(MINT), .SEGT(SEGT),
        .busy(busy), .upd(upd)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          at;
        logic [71:0] v;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    logic [7:0]  mem [256];
    logic [7:0]  lat;
    logic [7:0]  seq_addr [10] = '{8'hF0, 8'h21, 8'h22, 8'h23, 8'h24,
                                   8'h25, 8'h26, 8'h41, 8'h42, 8'h43};
    exp_t        upd_q[$];
    int          start_q[$];
    exp_t        got;
    logic [71:0] prev_out;
    logic [71:0] v1;
    logic [71:0] outv;

    assign outv = {SEG, MIN, HORA, DIA, MES, ANO, SEGT, MINT, HORAT};

    // Posedges since the last reset release.
    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // RTC model: latches the address, drives the addressed byte on reads.
    always @(posedge CLK) begin
        if (!CS_n && !AD_n) lat <= ad_out;
    end
    assign ad_in = !RD_n ? mem[lat] : 8'hEE;

    task automatic chk(input string name, input logic [71:0] act,
                       input logic [71:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp_v, cyc);
        end
    endtask

    function automatic logic [71:0] ref_vals();
        return {mem[8'h21], mem[8'h22], mem[8'h23], mem[8'h24], mem[8'h25],
                mem[8'h26], mem[8'h41], mem[8'h42], mem[8'h43]};
    endfunction

    task automatic rand_mem();
        for (int i = 1; i < 10; i++) mem[seq_addr[i]] = 8'($urandom);
    endtask

    // A sweep starting at posedge p (plus ext pause cycles) publishes
    // at posedge p+90+ext: 10 transactions of 4*TP+1 cycles.
    task automatic expect_sweep(input int p, input int ext);
        exp_t e;
        start_q.push_back(p);
        e.at = p + 10 * (4 * TP + 1) + ext;
        e.v  = ref_vals();
        upd_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic do_reset(input bit expect_empty);
        if (expect_empty && armed) begin
            chk("pending_upd", 72'(upd_q.size()), 72'(0));
            chk("pending_start", 72'(start_q.size()), 72'(0));
        end
        @(negedge CLK);
        #2;
        RST = 1'b1;
        armed = 1'b1;
        hold = 1'b0;
        rd_req = 1'b0;
        upd_q.delete();
        start_q.delete();
        #1;
        chk("rst_strobes", 72'({CS_n, AD_n, RD_n, WR_n}), 72'(4'hF));
        chk("rst_bus", 72'({ad_oe, ad_out}), 72'(0));
        chk("rst_outputs", outv, 72'(0));
        chk("rst_busy_upd", 72'({busy, upd}), 72'(0));
        repeat (3) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Publish monitor.
    always @(negedge CLK) begin
        if (RST || !armed) begin
            prev_out <= outv;
        end else begin
            if (upd) begin
                if (upd_q.size() == 0) begin
                    chk("unexpected_upd", 72'(cyc), 72'(0));
                end else begin
                    got = upd_q.pop_front();
                    chk("upd_cycle", 72'(cyc), 72'(got.at));
                    chk("publish", outv, got.v);
                end
            end else if (outv !== prev_out) begin
                chk("out_stable", outv, prev_out);
            end
            prev_out <= outv;
        end
    end

    // Bus protocol monitor.
    bit         prev_cs;
    int         seq, a_cnt, aw_cnt, dw_cnt, dr_cnt;
    logic [7:0] a_hold;

    always @(negedge CLK) begin
        if (RST || !armed) begin
            prev_cs <= 1'b1;
            seq     <= 0;
        end else begin
            if (!RD_n || !WR_n)
                chk("rd_wr_both_low", 72'(RD_n | WR_n), 72'(1));
            if (!RD_n)
                chk("oe_in_read", 72'(ad_oe), 72'(0));
            if (prev_cs && !CS_n) begin
                chk("tx_addr", 72'(ad_out), 72'(seq_addr[seq]));
                chk("tx_start_ad", 72'({AD_n, ad_oe}), 72'(2'b01));
                if (seq == 0) begin
                    if (start_q.size() == 0)
                        chk("unexpected_sweep", 72'(cyc), 72'(0));
                    else
                        chk("sweep_start", 72'(cyc), 72'(start_q.pop_front()));
                end
                a_cnt  <= 1;
                aw_cnt <= !WR_n ? 1 : 0;
                a_hold <= ad_out;
                dw_cnt <= 0;
                dr_cnt <= 0;
            end else if (!CS_n) begin
                if (!AD_n) begin
                    a_cnt <= a_cnt + 1;
                    if (!WR_n) aw_cnt <= aw_cnt + 1;
                    chk("addr_stable", 72'({ad_oe, ad_out}), 72'({1'b1, a_hold}));
                end else begin
                    if (!WR_n) begin
                        dw_cnt <= dw_cnt + 1;
                        chk("wr_data", 72'({ad_oe, ad_out}), 72'(9'h100));
                    end
                    if (!RD_n) dr_cnt <= dr_cnt + 1;
                end
            end else if (!prev_cs && CS_n) begin
                chk("addr_phase_len", 72'(a_cnt), 72'(2 * TP));
                chk("addr_wr_len", 72'(aw_cnt), 72'(TP));
                chk("data_wr_len", 72'(dw_cnt), 72'(seq == 0 ? TP : 0));
                chk("data_rd_len", 72'(dr_cnt), 72'(seq == 0 ? 0 : TP));
                seq <= (seq == 9) ? 0 : seq + 1;
            end
            prev_cs <= CS_n;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h21] = 8'h45; mem[8'h22] = 8'h59; mem[8'h23] = 8'h23;
        mem[8'h24] = 8'h31; mem[8'h25] = 8'h12; mem[8'h26] = 8'h24;
        mem[8'h41] = 8'h05; mem[8'h42] = 8'h30; mem[8'h43] = 8'h01;

        // Power-up sweep, then two refresh sweeps with random data.
        do_reset(1'b1);
        expect_sweep(1, 0);
        wait_cyc(92);
        chk("first_publish", outv,
            {8'h45, 8'h59, 8'h23, 8'h31, 8'h12, 8'h24, 8'h05, 8'h30, 8'h01});
        chk("idle_after_commit", 72'({busy, CS_n}), 72'(2'b01));
        wait_cyc(500);
        rand_mem();
        expect_sweep(1001, 0);
        wait_cyc(1000);
        chk("idle_before_refresh", 72'(busy), 72'(0));
        wait_cyc(1001);
        chk("busy_at_refresh", 72'(busy), 72'(1));
        wait_cyc(1500);
        rand_mem();
        expect_sweep(2001, 0);
        wait_cyc(2100);

        // Hold during index 3 data phase of a requested sweep.
        rand_mem();
        do_reset(1'b1);
        expect_sweep(1, 0);
        wait_cyc(100);
        v1 = ref_vals();
        rand_mem();
        rd_req = 1'b1;
        expect_sweep(102, 46);
        @(negedge CLK);
        rd_req = 1'b0;
        wait_cyc(133);
        hold = 1'b1;
        for (int c = 140; c <= 180; c += 8) begin
            wait_cyc(c);
            chk("pause_bus", 72'({CS_n, ad_oe, busy}), 72'(3'b101));
            chk("pause_outputs", outv, v1);
        end
        wait_cyc(183);
        hold = 1'b0;
        chk("pause_last", 72'(CS_n), 72'(1));
        wait_cyc(184);
        chk("resume_idx4", 72'({CS_n, AD_n, ad_out}), 72'({2'b00, 8'h24}));
        wait_cyc(240);

        // Two requests during one sweep collapse into one extra sweep.
        rand_mem();
        do_reset(1'b1);
        expect_sweep(1, 0);
        wait_cyc(40);
        rd_req = 1'b1;
        expect_sweep(93, 0);
        @(negedge CLK);
        rd_req = 1'b0;
        wait_cyc(60);
        rd_req = 1'b1;
        @(negedge CLK);
        rd_req = 1'b0;
        wait_cyc(92);
        chk("req_idle_gap", 72'(busy), 72'(0));
        wait_cyc(93);
        chk("req_restart", 72'(busy), 72'(1));
        wait_cyc(1050);

        // Reset in the middle of the second sweep.
        rand_mem();
        do_reset(1'b1);
        expect_sweep(1, 0);
        wait_cyc(100);
        mem[8'h21] = 8'h46;
        rd_req = 1'b1;
        expect_sweep(102, 0);
        @(negedge CLK);
        rd_req = 1'b0;
        wait_cyc(162);
        chk("mid_sweep_cs", 72'(CS_n), 72'(0));
        do_reset(1'b0);
        expect_sweep(1, 0);
        wait_cyc(92);
        chk("seg_after_reset", 72'(SEG), 72'(8'h46));
        wait_cyc(100);

        chk("pending_upd", 72'(upd_q.size()), 72'(0));
        chk("pending_start", 72'(start_q.size()), 72'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
